// File: rtl/cnn_mac_sched.sv
// cnn_mac_sched -- sequences one KLEN-term signed dot product through a
// shared, external 10x14 signed multiplier. It has a two-stage pipeline:
// operands are registered, then the product is registered, then the product
// is accumulated.
//
// Ports:
//   ap_clk, ap_rst        clock (rising edge), synchronous active-high reset
//   start, busy           begin one dot product / high whenever not IDLE
//   in_valid, in_ready    operand beat handshake (a_in 10b, b_in 14b, signed)
//   mul_a, mul_b, mul_p   registered operands out, combinational product in
//   out_valid, out_ready  result handshake, out_data is ACC_W signed
//
// Build option: define CNN_MAC_SAT_EN to clamp out_data to [-32768, 32767].
// When it is undefined, out_data is the raw wrapping accumulator.
module cnn_mac_sched #(
   parameter int KLEN  = 9,
   parameter int ACC_W = 32
) (
   input  logic             ap_clk,
   input  logic             ap_rst,
   input  logic             start,
   output logic             busy,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [9:0]       a_in,
   input  logic [13:0]      b_in,
   output logic [9:0]       mul_a,
   output logic [13:0]      mul_b,
   input  logic [24:0]      mul_p,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data
);

   localparam int CNT_W = $clog2(KLEN + 1);

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

   state_t                   state, state_nxt;
   logic [CNT_W-1:0]         cnt;
   logic [1:0]               vld_pipe;   // [0] operands valid, [1] product valid
   logic signed [24:0]       prod_r;
   logic signed [ACC_W-1:0]  acc;
   logic                     beat, last_beat;

   assign beat      = in_valid && (state == LOAD);
   assign last_beat = beat && (cnt == CNT_W'(KLEN - 1));

   // State register
   always_ff @(posedge ap_clk) begin
      if (ap_rst) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start)                       state_nxt = LOAD;
         LOAD:  if (last_beat)                   state_nxt = DRAIN;
         DRAIN: if (vld_pipe == 2'b00)           state_nxt = DONE;
         DONE:  if (out_ready)                   state_nxt = IDLE;
         default:                                state_nxt = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy      = (state != IDLE);
      in_ready  = (state == LOAD);
      out_valid = (state == DONE);
   end

   // Datapath. A start in IDLE clears the whole job context, so a new
   // dot product never sees residue from an abandoned or finished one.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         cnt      <= '0;
         vld_pipe <= '0;
         mul_a    <= '0;
         mul_b    <= '0;
         prod_r   <= '0;
         acc      <= '0;
      end else if (state == IDLE && start) begin
         cnt      <= '0;
         vld_pipe <= '0;
         acc      <= '0;
      end else begin
         vld_pipe <= {vld_pipe[0], beat};
         if (beat) begin
            mul_a <= a_in;
            mul_b <= b_in;
            cnt   <= cnt + 1'b1;
         end
         if (vld_pipe[0]) prod_r <= $signed(mul_p);
         // Sizing cast of a signed value sign-extends the product.
         if (vld_pipe[1]) acc <= acc + ACC_W'(prod_r);
      end
   end

`ifdef CNN_MAC_SAT_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

   always_comb begin
      if (acc > SAT_MAX)      out_data = SAT_MAX;
      else if (acc < SAT_MIN) out_data = SAT_MIN;
      else                    out_data = acc;
   end
`else
   assign out_data = acc;
`endif

endmodule

// File: tb/tb_cnn_mac_sched.sv
module tb_cnn_mac_sched;

   logic               ap_clk = 1'b0;
   logic               ap_rst, start, in_valid, out_ready;
   logic               busy, in_ready, out_valid;
   logic signed [9:0]  a_in, mul_a;
   logic signed [13:0] b_in, mul_b;
   logic [24:0]        mul_p;
   logic [31:0]        out_data;

   // Second instance with KLEN=1
   logic               start1, in_valid1, out_ready1;
   logic               busy1, in_ready1, out_valid1;
   logic signed [9:0]  a_in1, mul_a1;
   logic signed [13:0] b_in1, mul_b1;
   logic [24:0]        mul_p1;
   logic [31:0]        out_data1;

   int n_chk = 0;
   int n_err = 0;

   always #5 ap_clk = ~ap_clk;

   // Behavioural shared multiplier
   assign mul_p  = 25'(mul_a * mul_b);
   assign mul_p1 = 25'(mul_a1 * mul_b1);

   cnn_mac_sched #(.KLEN(9), .ACC_W(32)) dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .start(start), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
      .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));

   cnn_mac_sched #(.KLEN(1), .ACC_W(32)) dut1 (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .start(start1), .busy(busy1),
      .in_valid(in_valid1), .in_ready(in_ready1), .a_in(a_in1), .b_in(b_in1),
      .mul_a(mul_a1), .mul_b(mul_b1), .mul_p(mul_p1),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1));

   task automatic chk(input string tag, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   // Starts a KLEN=9 job, feeds 9 beats with `gap` idle cycles after each one
   // and checks the 3-cycle latency.
   // out_ready is held low, so the result stays waiting in DONE.
   task automatic run_dot(input string tag, input int a, input int b, input int gap);
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1; a_in = 10'(a); b_in = 14'(b);
         tick();
         in_valid = 1'b0;
         for (int g = 0; g < gap && i < 8; g++) tick();
      end
      for (int k = 1; k <= 3; k++) begin
         chk({tag, "_in_ready_drain"}, in_ready, 0);
         if (k < 3) begin
            tick();
            chk({tag, "_early_valid"}, out_valid, (k == 3));
         end else begin
            tick();
            chk({tag, "_lat3_valid"}, out_valid, 1);
         end
      end
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      chk({tag, "_idle_busy"}, busy, 0);
      chk({tag, "_idle_valid"}, out_valid, 0);
   endtask

   initial begin
      longint held;
      ap_rst = 1'b1; start = 0; in_valid = 0; out_ready = 0; a_in = 0; b_in = 0;
      start1 = 0; in_valid1 = 0; out_ready1 = 0; a_in1 = 0; b_in1 = 0;
      tick(); tick();
      ap_rst = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_mul_a", mul_a, 0);
      chk("rst_mul_b", mul_b, 0);

      // All ones
      run_dot("ones", 1, 1, 0);
      chk("ones_data", $signed(out_data), 9);
      handshake("ones");

      // Large positive
      run_dot("negneg", -512, -8192, 0);
`ifdef CNN_MAC_SAT_EN
      chk("negneg_data", $signed(out_data), 32767);
`else
      chk("negneg_data", $signed(out_data), 37748736);
`endif
      handshake("negneg");

      // Large negative
      run_dot("negpos", -512, 8191, 0);
`ifdef CNN_MAC_SAT_EN
      chk("negpos_data", $signed(out_data), -32768);
`else
      chk("negpos_data", $signed(out_data), -37744128);
`endif
      handshake("negpos");

      // Bubbles between beats, then backpressure in DONE and an ignored start
      run_dot("bubble", 3, -5, 2);
      chk("bubble_data", $signed(out_data), -135);
      held = $signed(out_data);
      for (int i = 0; i < 5; i++) begin
         start = (i == 2);
         tick();
         chk("hold_valid", out_valid, 1);
         chk("hold_data", $signed(out_data), held);
         chk("hold_in_ready", in_ready, 0);
      end
      start = 1'b0;
      handshake("hold");

      // Reset in the middle of LOAD
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; a_in = 10'sd7; b_in = 14'sd9; tick();
      end
      in_valid = 1'b0;
      ap_rst = 1'b1; tick(); ap_rst = 1'b0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_data", out_data, 0);
      chk("mid_rst_mul_a", mul_a, 0);
      chk("mid_rst_mul_b", mul_b, 0);
      run_dot("after_rst", 2, 2, 0);
      chk("after_rst_data", $signed(out_data), 36);
      handshake("after_rst");

      // KLEN=1
      start1 = 1'b1; tick(); start1 = 1'b0;
      chk("k1_in_ready", in_ready1, 1);
      in_valid1 = 1'b1; a_in1 = 10'sd511; b_in1 = 14'sd8191; tick();
      in_valid1 = 1'b0;
      chk("k1_drain_in_ready", in_ready1, 0);
      tick(); chk("k1_valid_1", out_valid1, 0);
      tick(); chk("k1_valid_2", out_valid1, 0);
      tick(); chk("k1_valid_3", out_valid1, 1);
`ifdef CNN_MAC_SAT_EN
      chk("k1_data", $signed(out_data1), 32767);
`else
      chk("k1_data", $signed(out_data1), 4185601);
`endif
      out_ready1 = 1'b1; tick(); out_ready1 = 1'b0;
      chk("k1_idle_busy", busy1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/cnn_mac_sched.md
CNN_MAC_SCHED -- requirements
Module: cnn_mac_sched

Interface
REQ-001 SHALL provide parameter KLEN, default 9: number of products per dot product; legal range 1..256.
REQ-002 SHALL provide parameter ACC_W, default 32: accumulator and result width; ACC_W >= 25.
REQ-003 SHALL provide ap_clk  input  1  sole clock, rising edge.
REQ-004 SHALL provide ap_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL provide start  input  1  pulse that begins one dot product.
REQ-006 SHALL provide busy  output  1  high in every state except IDLE.
REQ-007 SHALL provide in_valid / in_ready  input / output  1 / 1  operand-beat handshake.
REQ-008 SHALL provide a_in  input  10  signed activation; b_in  input  14  signed weight.
REQ-009 SHALL provide mul_a  output  10  and mul_b  output  14  registered operands to the shared signed 10x14 multiplier.
REQ-010 SHALL provide mul_p  input  25  signed combinational product returned by that multiplier.
REQ-011 SHALL provide out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-012 SHALL provide out_data  output  ACC_W  signed dot-product result.

Function
REQ-013 SHALL implement states IDLE, LOAD, DRAIN, DONE.
REQ-014 IDLE->LOAD on start=1; accumulator, beat counter and pipeline valid bits cleared in the same edge.
REQ-015 start while busy=1 SHALL be ignored, with no effect on the count or accumulator.
REQ-016 in_ready SHALL equal (state==LOAD); a beat is accepted when in_valid&in_ready.
REQ-017 Accepted beat at edge N: mul_a/mul_b registered at N with stage-1 valid set; mul_p captured into prod_r at N+1 with stage-2 valid set; sign-extended prod_r added to the accumulator at N+2.
REQ-018 mul_a/mul_b SHALL hold their last value when no beat is accepted; the accumulator SHALL only update when stage-2 valid is set.
REQ-019 In-bubbles (in_valid=0) SHALL stall the count without corrupting the pipeline.
REQ-020 LOAD->DRAIN on the edge accepting beat KLEN; DRAIN->DONE when both pipeline valid bits are clear.
REQ-021 out_valid SHALL be 1 only in DONE, with out_data stable while out_ready=0.
REQ-022 Latency: out_valid SHALL rise exactly 3 cycles after the edge accepting the last beat.
REQ-023 DONE->IDLE on out_valid&out_ready; start SHALL be accepted in IDLE on the following cycle at the earliest.
REQ-024 Arithmetic: full signed product sign-extended to ACC_W; accumulation wraps two's complement, no overflow flag.
REQ-025 KLEN=1: a single beat SHALL give LOAD->DRAIN immediately, with identical latency.

Reset
REQ-026 ap_rst=1 SHALL force state=IDLE, with busy, in_ready, out_valid=0, out_data=0, mul_a=0, mul_b=0, accumulator, counter and valid bits=0.
REQ-027 Reset asserted in any state, including mid-LOAD or DONE with out_ready=0, SHALL abandon the operation; no partial result is emitted.
REQ-028 Reset SHALL take priority over start and every handshake on the same edge.

Configuration
REQ-029 Macro CNN_MAC_SAT_EN defined: out_data SHALL be the accumulator clamped to [-32768, 32767], sign-extended to ACC_W.
REQ-030 Macro CNN_MAC_SAT_EN undefined: out_data SHALL equal the raw ACC_W accumulator, and no clamp logic is present.

Verification
REQ-031 KLEN=9, start, 9 back-to-back beats a=1 b=1 -> out_valid 3 cycles after beat 9, out_data=9.
REQ-032 KLEN=9, 9 beats a=-512 b=-8192 -> out_data=37748736 (SAT off) / 32767 (SAT on); a=-512 b=8191 -> -37744128 / -32768.
REQ-033 KLEN=9, a=3 b=-5 with in_valid low for 2 cycles between beats -> out_data=-135; in_ready low in DRAIN/DONE.
REQ-034 out_ready held low 5 cycles in DONE -> out_valid and out_data stable; second start during DONE ignored; IDLE one cycle after handshake.
REQ-035 ap_rst pulsed after beat 4 -> all outputs 0 next cycle; new start with 9 beats a=2 b=2 -> out_data=36, no residue.
REQ-036 KLEN=1, a=511 b=8191 -> out_data=4185601 (SAT off) / 32767 (SAT on), with latency of 3 cycles.
